// File: rtl/frame_counter_ctrl.sv
// ---------------------------------------------------------------------------
// frame_counter_ctrl
//
// Sequencer between the CPU bus and the APU frame counter. It captures
// $4017 writes and replays them to the frame counter one CPU cycle later.
// When FC_CTRL_WRITE_DELAY_EN is defined, the replay instead follows the
// hardware-accurate 3/4 CPU-cycle delay. The block also raises the
// immediate quarter/half clocks that 5-step mode requires, and it services
// $4015 status reads, including the read-to-clear of the frame IRQ flag.
//
// Build option:
//   FC_CTRL_WRITE_DELAY_EN  defined   -> write replayed after DELAY_ALIGNED /
//                                        DELAY_UNALIGNED CPU cycles
//                           undefined -> write replayed on the next CPU cycle
//                                        (DELAY_* parameters have no effect)
//
// Parameters:
//   DELAY_ALIGNED    CPU cycles from write to APPLY when apu_clk_en=1 (>=2)
//   DELAY_UNALIGNED  CPU cycles from write to APPLY when apu_clk_en=0 (>=2)
//
// Ports:
//   clk                 in   system clock
//   rst_l               in   asynchronous active-low reset
//   cpu_clk_en          in   CPU cycle strobe, all state advances only here
//   apu_clk_en          in   APU cycle strobe (every second CPU cycle)
//   addr[15:0]          in   CPU bus address
//   data_in[7:0]        in   CPU write data
//   we / re             in   CPU write / read strobes
//   irq_flag_in         in   frame counter interrupt flag
//   fc_addr[15:0]       out  address to frame counter (4017 during APPLY)
//   fc_data[7:0]        out  data to frame counter ({pend_data, 6'b0})
//   fc_we               out  frame counter write strobe
//   fc_clear_interrupt  out  frame IRQ clear ($4015 read or inhibit write)
//   force_quarter       out  extra quarter-frame clock (5-step mode write)
//   force_half          out  extra half-frame clock (5-step mode write)
//   status_frame_irq    out  bit 6 of $4015 read data
//   busy                out  a $4017 write is pending
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | nothing pending
// WAIT   | write captured, counting down to the replay cycle
// APPLY  | replay cycle: write strobe, forced clocks, inhibit clear
// ---------------------------------------------------------------------------
module frame_counter_ctrl #(
  parameter int DELAY_ALIGNED   = 3,
  parameter int DELAY_UNALIGNED = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cpu_clk_en,
  input  logic        apu_clk_en,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        we,
  input  logic        re,
  input  logic        irq_flag_in,
  output logic [15:0] fc_addr,
  output logic [7:0]  fc_data,
  output logic        fc_we,
  output logic        fc_clear_interrupt,
  output logic        force_quarter,
  output logic        force_half,
  output logic        status_frame_irq,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  localparam int DELAY_MAX = (DELAY_ALIGNED > DELAY_UNALIGNED) ?
                             DELAY_ALIGNED : DELAY_UNALIGNED;
  localparam int CNT_W     = ($clog2(DELAY_MAX) > 3) ? $clog2(DELAY_MAX) : 3;

  // The write cycle and the APPLY cycle are not spent in WAIT, so the
  // counter starts at D-2 and APPLY follows the WAIT cycle that sees zero.
  localparam logic [CNT_W-1:0] LOAD_ALIGNED   = CNT_W'(DELAY_ALIGNED - 2);
  localparam logic [CNT_W-1:0] LOAD_UNALIGNED = CNT_W'(DELAY_UNALIGNED - 2);

`ifdef FC_CTRL_WRITE_DELAY_EN
  localparam logic [1:0] ST_AFTER_WRITE = ST_WAIT;
`else
  localparam logic [1:0] ST_AFTER_WRITE = ST_APPLY;
`endif

  logic [1:0]       r_state;
  logic [1:0]       r_pend_data;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_state_nxt;
  logic [1:0]       w_pend_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_load;
  logic             w_wr4017;
  logic             w_rd4015;
  logic             w_in_apply;
  logic             w_apply_strobe;

  // The frame counter only uses bits 7:6 of a $4017 write.
  logic             w_unused_data;
  assign w_unused_data = &{1'b0, data_in[5:0]};

  assign w_wr4017 = cpu_clk_en & we & (addr == 16'h4017);
  assign w_rd4015 = cpu_clk_en & re & (addr == 16'h4015);
  assign w_load   = apu_clk_en ? LOAD_ALIGNED : LOAD_UNALIGNED;

  // A new write always wins: it restarts the delay from WAIT, and from
  // APPLY it queues behind the replay that is completing this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_data;
    w_cnt_nxt   = r_cnt;
    if (w_wr4017) begin
      w_state_nxt = ST_AFTER_WRITE;
      w_pend_nxt  = data_in[7:6];
      w_cnt_nxt   = w_load;
    end else if (cpu_clk_en) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_APPLY;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        ST_APPLY: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= ST_IDLE;
      r_pend_data <= 2'b00;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_data <= w_pend_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign w_in_apply     = (r_state == ST_APPLY);
  assign w_apply_strobe = w_in_apply & cpu_clk_en;

  assign fc_addr = w_in_apply ? 16'h4017 : 16'h0000;
  assign fc_data = w_in_apply ? {r_pend_data, 6'b000000} : 8'h00;
  assign fc_we   = w_apply_strobe;

  // pend_data[1] = 5-step mode, pend_data[0] = IRQ inhibit
  assign force_quarter = w_apply_strobe & r_pend_data[1];
  assign force_half    = w_apply_strobe & r_pend_data[1];

  // A $4015 read that lands on APPLY still yields a single clear pulse.
  assign fc_clear_interrupt = w_rd4015 | (w_apply_strobe & r_pend_data[0]);

  // Status is the pre-clear flag; the clear takes effect in the frame counter.
  assign status_frame_irq = irq_flag_in;
  assign busy             = (r_state != ST_IDLE);

endmodule

// File: doc/frame_counter_ctrl.md
# frame_counter_ctrl

Sequencer sitting between the CPU bus and the APU frame counter. It owns every configuration access to the frame counter: it buffers `$4017` writes and replays them to the frame counter after the hardware-accurate 3/4 CPU-cycle delay. It issues the immediate quarter/half clocks required when 5-step mode is selected, and it services `$4015` status reads, including the read-to-clear of the frame interrupt flag.

## Interface
Parameters:
- DELAY_ALIGNED, default 3 — CPU cycles from a `$4017` write to APPLY when the write cycle has `apu_clk_en` high; legal range ≥2.
- DELAY_UNALIGNED, default 4 — CPU cycles from a `$4017` write to APPLY when the write cycle has `apu_clk_en` low; legal range ≥2.

Ports:
- clk  in  1  system clock
- rst_l  in  1  asynchronous, active-low reset
- cpu_clk_en  in  1  CPU cycle strobe; all state advances only when high
- apu_clk_en  in  1  APU cycle strobe; always coincident with a `cpu_clk_en`, every second CPU cycle
- addr  in  16  CPU bus address
- data_in  in  8  CPU write data
- we  in  1  CPU write strobe
- re  in  1  CPU read strobe
- irq_flag_in  in  1  frame counter `interrupt` output
- fc_addr  out  16  address presented to the frame counter
- fc_data  out  8  data presented to the frame counter
- fc_we  out  1  frame counter write strobe
- fc_clear_interrupt  out  1  frame counter interrupt clear
- force_quarter  out  1  extra quarter-frame clock enable, ORed downstream with the frame counter's quarter clock
- force_half  out  1  extra half-frame clock enable, ORed downstream with the frame counter's half clock
- status_frame_irq  out  1  bit 6 of `$4015` read data
- busy  out  1  a `$4017` write is pending

## Operation
- **Write detection:** `wr4017 = cpu_clk_en & we & (addr == 16'h4017)`.
- **Read detection:** `rd4015 = cpu_clk_en & re & (addr == 16'h4015)`.
- **FSM states:** IDLE, WAIT, APPLY.
  - Transitions are evaluated only on cycles with `cpu_clk_en` high.
  - A wait counter of 3 bits is used; with `FC_CTRL_WRITE_DELAY_EN` it must be wide enough for the larger delay.
- **IDLE:** on `wr4017`, latch `data_in[7:6]` into `pend_data`, load the counter, and go to WAIT.
- **WAIT:** the counter decrements each CPU cycle. APPLY is entered exactly D CPU cycles after the write cycle N:
  - D = DELAY_ALIGNED if `apu_clk_en` was high at N;
  - D = DELAY_UNALIGNED otherwise.
- **APPLY** (one CPU cycle):
  - `fc_addr` = 16'h4017, `fc_data` = {`pend_data`, 6'b0}, `fc_we` = `cpu_clk_en`.
  - If `pend_data[1]` (mode bit) = 1: `force_quarter` = `force_half` = `cpu_clk_en`.
  - If `pend_data[0]` (inhibit bit) = 1: `fc_clear_interrupt` = `cpu_clk_en`.
  - Next state is IDLE.
- **Outside APPLY:** `fc_addr` = 0, `fc_data` = 0, `fc_we` = 0, `force_*` = 0.
- **Status read:**
  - `status_frame_irq` = `irq_flag_in`, combinational, sampled before the clear.
  - `rd4015` asserts `fc_clear_interrupt` in the same cycle.
  - `fc_clear_interrupt` is the OR of the read clear and the APPLY inhibit clear.
- **`busy`:** `state != IDLE`.

## Timing
- **Reset:** state IDLE, `pend_data` = 0, counter = 0. All outputs are 0 except `status_frame_irq`, which follows `irq_flag_in`.
- **Reset mid-operation:** a pending write is discarded; no APPLY is ever issued for it.
- **`wr4017` during WAIT:** the newest data replaces `pend_data` and the delay restarts from the new write cycle. Only one APPLY is issued.
- **`wr4017` during APPLY:** APPLY completes with the old data, the new data is latched, and the state goes to WAIT (not IDLE). The second APPLY occurs D cycles after the second write.
- **`rd4015` coincident with APPLY:** one `fc_clear_interrupt` pulse (OR). The frame counter's own set priority governs the result.
- **Latency:** write at CPU cycle N gives `fc_we` at CPU cycle N+3 (aligned) or N+4 (unaligned). `status_frame_irq` has 0 latency.
- **Output pulse width:** all pulse outputs are high for exactly one `clk` cycle, the one where `cpu_clk_en` is high.
- **Idle cycles:** cycles with `cpu_clk_en` low never change state or outputs.

## Configuration
- **`FC_CTRL_WRITE_DELAY_EN` defined:** 3/4-cycle delayed APPLY as above.
- **`FC_CTRL_WRITE_DELAY_EN` undefined:**
  - WAIT is skipped; APPLY occurs at N+1 regardless of `apu_clk_en`.
  - The DELAY_* parameters are ignored.
  - Overlap rules still hold: a write during APPLY produces a second APPLY at the following CPU cycle.

## Test plan
- **Aligned delay:** reset, then write `$4017` = 8'h00 with `apu_clk_en` = 1 at CPU cycle 10 → `fc_we` = 1 only at CPU cycle 13, `fc_data` = 8'h00, `force_*` = 0, `busy` high cycles 11–13.
- **Unaligned delay, mode and inhibit:** write 8'hC0 with `apu_clk_en` = 0 at cycle 11 → at cycle 15, `fc_we` = `force_quarter` = `force_half` = `fc_clear_interrupt` = 1 and `fc_data` = 8'hC0.
- **Rewrite during WAIT:** write 8'h80 at cycle 20 (aligned), then 8'h00 at cycle 22 (aligned) → single APPLY at cycle 25 with data 8'h00, no `force_*`.
- **Status read-to-clear:** `irq_flag_in` = 1, read `$4015` → `status_frame_irq` = 1 and `fc_clear_interrupt` = 1 in the read cycle. A read of `$4016` leaves `fc_clear_interrupt` = 0.
- **Reset mid-WAIT:** write 8'h80, then assert `rst_l` low 2 CPU cycles later → no `fc_we` or `force_*` ever; `busy` = 0 immediately.
- **Write during APPLY:** write 8'h40 at cycle 30 (aligned), write 8'h80 at cycle 33 (unaligned, coincides with APPLY) → APPLY 8'h40 at cycle 33, APPLY 8'h80 at cycle 37 with `force_*` = 1.
